// File: rtl/vdcm_bitparse_pkg.sv
// Shared defaults and width helpers for the VDC-M bitstream parser.
package vdcm_bitparse_pkg;

    localparam int DATA_W_DEF  = 128;
    localparam int SE_MAX_DEF  = 128;
    localparam int BITS_READ_W = 32;

    // Bits needed to hold a count in the range 0..max_val.
    function automatic int cnt_w(input int max_val);
        return $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/ssm_barrel_shift.sv
// Combinational buffer realignment: drop consumed MSBs and merge a new word
// directly below the surviving bits.
module ssm_barrel_shift #(
    parameter int W    = 256,
    parameter int DW   = 128,
    parameter int SH_W = 9
) (
    input  logic [W-1:0]    data_i,
    input  logic [SH_W-1:0] shamt_i,
    input  logic [DW-1:0]   word_i,
    input  logic            word_en_i,
    input  logic [SH_W-1:0] pos_i,
    output logic [W-1:0]    data_o
);

    logic [W-1:0] kept;
    logic [W-1:0] word_al;

    always_comb begin
        kept    = data_i << shamt_i;
        word_al = '0;
        if (word_en_i) begin
            word_al = {word_i, {(W-DW){1'b0}}} >> pos_i;
        end
        data_o = kept | word_al;
    end

endmodule

// File: rtl/ssm_funnel_shifter.sv
// MSB-aligned bit funnel: appends input words, exposes an SE_MAX-bit peek
// window and consumes a variable number of bits per cycle.
module ssm_funnel_shifter
    import vdcm_bitparse_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int SE_MAX = SE_MAX_DEF,
    parameter int BUF_W  = DATA_W + SE_MAX
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     init,
    input  logic [DATA_W-1:0]        in_data,
    input  logic                     in_valid,
    output logic                     in_ready,
    output logic [SE_MAX-1:0]        peek_data,
    output logic                     peek_valid,
    input  logic                     cons_en,
    input  logic [cnt_w(SE_MAX)-1:0] cons_len,
    output logic [cnt_w(BUF_W)-1:0]  fullness,
    output logic [BITS_READ_W-1:0]   bits_read,
    output logic                     err_underrun
);

    localparam int FW = cnt_w(BUF_W);

    logic [BUF_W-1:0]       bits_q, bits_d, shift_out;
    logic [FW-1:0]          fill_q, fill_d;
    logic [BITS_READ_W-1:0] rd_q, rd_d;
    logic                   err_q, err_d;

    logic          accept;
    logic          cons_ok;
    logic [FW-1:0] len_x;
    logic [FW-1:0] shamt;
    logic [FW-1:0] rem;

    // Ready looks only at registered fill so cons_en never reaches in_ready.
    assign in_ready   = (fill_q <= FW'(BUF_W - DATA_W));
    assign peek_data  = bits_q[BUF_W-1 -: SE_MAX];
    assign peek_valid = (fill_q >= FW'(SE_MAX));
    assign fullness   = fill_q;
    assign bits_read  = rd_q;
    assign err_underrun = err_q;

    assign accept  = in_valid & in_ready;
    assign len_x   = FW'(cons_len);
    assign cons_ok = cons_en & (len_x <= fill_q);
    assign shamt   = cons_ok ? len_x : '0;
    assign rem     = fill_q - shamt;

    ssm_barrel_shift #(
        .W    (BUF_W),
        .DW   (DATA_W),
        .SH_W (FW)
    ) u_shift (
        .data_i    (bits_q),
        .shamt_i   (shamt),
        .word_i    (in_data),
        .word_en_i (accept),
        .pos_i     (rem),
        .data_o    (shift_out)
    );

    always_comb begin
        bits_d = shift_out;
        fill_d = rem + (accept ? FW'(DATA_W) : '0);
        rd_d   = rd_q + (cons_ok ? BITS_READ_W'(cons_len) : '0);
        err_d  = err_q | (cons_en & ~cons_ok);
        if (init) begin
            bits_d = '0;
            fill_d = '0;
            rd_d   = '0;
            err_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            bits_q <= '0;
            fill_q <= '0;
            rd_q   <= '0;
            err_q  <= 1'b0;
        end else begin
            bits_q <= bits_d;
            fill_q <= fill_d;
            rd_q   <= rd_d;
            err_q  <= err_d;
        end
    end

endmodule

// File: tb/tb_ssm_funnel_shifter.sv
// Bench for ssm_funnel_shifter: bit-queue reference model plus directed
// literal checks of the key corner cases.
module tb_ssm_funnel_shifter;

    logic         clk = 1'b0;
    logic         rstn = 1'b0;
    logic         init = 1'b0;
    logic [127:0] in_data = '0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [127:0] peek_data;
    logic         peek_valid;
    logic         cons_en = 1'b0;
    logic [7:0]   cons_len = '0;
    logic [8:0]   fullness;
    logic [31:0]  bits_read;
    logic         err_underrun;

    ssm_funnel_shifter dut (
        .clk          (clk),
        .rstn         (rstn),
        .init         (init),
        .in_data      (in_data),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .peek_data    (peek_data),
        .peek_valid   (peek_valid),
        .cons_en      (cons_en),
        .cons_len     (cons_len),
        .fullness     (fullness),
        .bits_read    (bits_read),
        .err_underrun (err_underrun)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_fail = 0;
    bit cmp_en = 1'b0;

    // Reference model: unread bits in stream order, front = oldest.
    bit          mq[$];
    logic [31:0] m_read = '0;
    bit          m_err = 1'b0;

    logic [127:0] W1 = {{31{4'hF}}, 4'h0};
    logic [127:0] W2 = {16{8'h0F}};
    logic [127:0] W3 = 128'h0123456789ABCDEF_FEDCBA9876543210;
    logic [255:0] cat;

    task automatic chk(input string nm, input logic [127:0] act,
                       input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [127:0] m_peek();
        logic [127:0] r;
        r = '0;
        for (int i = 0; i < 128; i++) begin
            if (i < mq.size()) r[127-i] = mq[i];
        end
        return r;
    endfunction

    task automatic m_clear();
        mq.delete();
        m_read = '0;
        m_err  = 1'b0;
    endtask

    // Applies the current inputs to the model as of a rising edge.
    task automatic model_update();
        bit acc;
        int len;
        if (!rstn || init) begin
            m_clear();
            return;
        end
        acc = in_valid && (mq.size() <= 128);
        len = int'(cons_len);
        if (cons_en) begin
            if (len <= mq.size()) begin
                for (int i = 0; i < len; i++) void'(mq.pop_front());
                m_read = m_read + 32'(len);
            end else begin
                m_err = 1'b1;
            end
        end
        if (acc) begin
            for (int i = 127; i >= 0; i--) mq.push_back(in_data[i]);
        end
    endtask

    task automatic step(input bit iv, input logic [127:0] w, input bit ce,
                        input int cl, input bit ini);
        in_valid = iv;
        in_data  = w;
        cons_en  = ce;
        cons_len = 8'(cl);
        init     = ini;
        @(posedge clk);
        model_update();
        #1;
    endtask

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("m_fullness", 128'(fullness), 128'(mq.size()));
            chk("m_peek", peek_data, m_peek());
            chk("m_peek_valid", 128'(peek_valid), 128'(mq.size() >= 128));
            chk("m_in_ready", 128'(in_ready), 128'(mq.size() <= 128));
            chk("m_bits_read", 128'(bits_read), 128'(m_read));
            chk("m_err", 128'(err_underrun), 128'(m_err));
        end
    end

    initial begin
        cat = {W1, W2};
        repeat (2) @(posedge clk);
        #1;
        chk("rst_fullness", 128'(fullness), 128'd0);
        chk("rst_peek", peek_data, 128'd0);
        chk("rst_peek_valid", 128'(peek_valid), 128'd0);
        chk("rst_in_ready", 128'(in_ready), 128'd1);
        chk("rst_bits_read", 128'(bits_read), 128'd0);
        chk("rst_err", 128'(err_underrun), 128'd0);
        rstn = 1'b1;
        m_clear();
        cmp_en = 1'b1;

        step(1, W1, 0, 0, 0);
        chk("w1_fullness", 128'(fullness), 128'd128);
        chk("w1_peek", peek_data, W1);
        chk("w1_in_ready", 128'(in_ready), 128'd1);
        step(1, W2, 0, 0, 0);
        chk("w2_fullness", 128'(fullness), 128'd256);
        chk("w2_in_ready", 128'(in_ready), 128'd0);
        chk("w2_peek", peek_data, W1);
        chk("w2_peek_valid", 128'(peek_valid), 128'd1);
        // in_valid while full must not be accepted
        step(1, W3, 1, 3, 0);
        chk("c3_fullness", 128'(fullness), 128'd253);
        chk("c3_peek", peek_data, cat[252:125]);
        chk("c3_bits_read", 128'(bits_read), 128'd3);
        step(0, '0, 1, 125, 0);
        chk("c125_fullness", 128'(fullness), 128'd128);
        chk("c125_peek", peek_data, W2);
        step(1, W3, 1, 128, 0);
        chk("swap_fullness", 128'(fullness), 128'd128);
        chk("swap_peek", peek_data, W3);
        chk("swap_bits_read", 128'(bits_read), 128'd256);
        step(0, '0, 1, 123, 0);
        chk("tail_fullness", 128'(fullness), 128'd5);
        chk("tail_peek", peek_data, {5'b10000, 123'd0});
        chk("tail_peek_valid", 128'(peek_valid), 128'd0);
        step(0, '0, 1, 6, 0);
        chk("under_err", 128'(err_underrun), 128'd1);
        chk("under_fullness", 128'(fullness), 128'd5);
        chk("under_bits_read", 128'(bits_read), 128'd379);
        step(0, '0, 0, 0, 0);
        chk("sticky_err", 128'(err_underrun), 128'd1);
        step(0, '0, 1, 5, 0);
        chk("drain_fullness", 128'(fullness), 128'd0);
        chk("drain_bits_read", 128'(bits_read), 128'd384);
        chk("drain_err", 128'(err_underrun), 128'd1);
        chk("drain_peek", peek_data, 128'd0);
        step(1, W1, 0, 0, 0);
        step(1, W2, 1, 7, 1);
        chk("init_fullness", 128'(fullness), 128'd0);
        chk("init_bits_read", 128'(bits_read), 128'd0);
        chk("init_err", 128'(err_underrun), 128'd0);
        chk("init_in_ready", 128'(in_ready), 128'd1);
        step(0, '0, 1, 0, 0);
        chk("zero_len_fullness", 128'(fullness), 128'd0);
        chk("zero_len_err", 128'(err_underrun), 128'd0);

        for (int c = 0; c < 10000; c++) begin
            logic [127:0] w;
            w = {$urandom(), $urandom(), $urandom(), $urandom()};
            step(($urandom_range(0, 9) < 7), w, ($urandom_range(0, 3) != 0),
                 $urandom_range(0, 128), ($urandom_range(0, 299) == 0));
        end

        // Asynchronous reset in the middle of activity.
        step(1, W3, 0, 0, 0);
        in_valid = 1'b1;
        in_data  = W1;
        cons_en  = 1'b1;
        cons_len = 8'd9;
        #2;
        rstn = 1'b0;
        m_clear();
        #1;
        chk("arst_fullness", 128'(fullness), 128'd0);
        chk("arst_peek", peek_data, 128'd0);
        chk("arst_in_ready", 128'(in_ready), 128'd1);
        step(1, W1, 1, 9, 0);
        step(1, W1, 1, 9, 0);
        rstn = 1'b1;
        step(0, '0, 0, 0, 0);
        chk("post_rst_fullness", 128'(fullness), 128'd0);
        chk("post_rst_bits_read", 128'(bits_read), 128'd0);
        chk("post_rst_err", 128'(err_underrun), 128'd0);
        step(0, '0, 0, 0, 0);

        cmp_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
